// File: rtl/regfile_wb_arbiter_pkg.sv
// regfile_wb_arbiter_pkg: shared widths and arbiter state encoding for the writeback arbiter
package regfile_wb_arbiter_pkg;
  localparam int REG_ADDR_W = 5;
  localparam int XLEN = 32;
  typedef enum logic {
    PRIO_B = 1'b0,
    PRIO_A = 1'b1
  } prio_state_e;
endpackage

// File: rtl/regfile_wb_prio.sv
// regfile_wb_prio: fixed-priority-to-B grant with a starvation guard that promotes A after MAX_WAIT held cycles
module regfile_wb_prio
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int MAX_WAIT = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic a_valid,
  input  logic b_valid,
  output logic a_grant,
  output logic b_grant
);
  localparam logic [3:0] MAX_W = 4'(MAX_WAIT);
  prio_state_e state, state_n;
  logic [3:0] wait_cnt, wait_n;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= PRIO_B;
      wait_cnt <= '0;
    end else begin
      state <= state_n;
      wait_cnt <= wait_n;
    end
  end
  // PRIO_A mirrors wait_cnt having reached MAX_WAIT, so it also drops when A withdraws
  always_comb begin
    a_grant = !rst && a_valid && (!b_valid || state == PRIO_A);
    b_grant = !rst && b_valid && !a_grant;
    wait_n = (a_valid && !a_grant) ? ((wait_cnt == MAX_W) ? wait_cnt : wait_cnt + 4'd1) : 4'd0;
    state_n = (wait_n == MAX_W) ? PRIO_A : PRIO_B;
  end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: shares the register-file write port between execute (A) and memory (B) writeback.
// Define REGFILE_WB_FWD_EN to add read-address forwarding against the registered write.
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int MAX_WAIT = 3,
  parameter int CNT_W = 16
) (
  input  logic                  i_regfile_wb_arbiter_clk,
  input  logic                  i_regfile_wb_arbiter_rst,
  input  logic                  i_regfile_wb_arbiter_aValid,
  input  logic [REG_ADDR_W-1:0] i_regfile_wb_arbiter_aAddr,
  input  logic [XLEN-1:0]       i_regfile_wb_arbiter_aData,
  output logic                  o_regfile_wb_arbiter_aReady,
  input  logic                  i_regfile_wb_arbiter_bValid,
  input  logic [REG_ADDR_W-1:0] i_regfile_wb_arbiter_bAddr,
  input  logic [XLEN-1:0]       i_regfile_wb_arbiter_bData,
  output logic                  o_regfile_wb_arbiter_bReady,
  output logic                  o_regfile_wb_arbiter_we,
  output logic [REG_ADDR_W-1:0] o_regfile_wb_arbiter_writeAddr,
  output logic [XLEN-1:0]       o_regfile_wb_arbiter_writeData,
`ifdef REGFILE_WB_FWD_EN
  input  logic [REG_ADDR_W-1:0] i_regfile_wb_arbiter_ra1,
  input  logic [REG_ADDR_W-1:0] i_regfile_wb_arbiter_ra2,
  output logic                  o_regfile_wb_arbiter_fwd1,
  output logic                  o_regfile_wb_arbiter_fwd2,
  output logic [XLEN-1:0]       o_regfile_wb_arbiter_fwdData,
`endif
  output logic [CNT_W-1:0]      o_regfile_wb_arbiter_conflicts
);
  logic a_grant, b_grant, xfer;
  logic [REG_ADDR_W-1:0] g_addr;
  logic [XLEN-1:0] g_data;
  regfile_wb_prio #(.MAX_WAIT(MAX_WAIT)) u_prio (
    .clk     (i_regfile_wb_arbiter_clk),
    .rst     (i_regfile_wb_arbiter_rst),
    .a_valid (i_regfile_wb_arbiter_aValid),
    .b_valid (i_regfile_wb_arbiter_bValid),
    .a_grant (a_grant),
    .b_grant (b_grant)
  );
  assign o_regfile_wb_arbiter_aReady = a_grant;
  assign o_regfile_wb_arbiter_bReady = b_grant;
  always_comb begin
    xfer = a_grant || b_grant;
    g_addr = a_grant ? i_regfile_wb_arbiter_aAddr : i_regfile_wb_arbiter_bAddr;
    g_data = a_grant ? i_regfile_wb_arbiter_aData : i_regfile_wb_arbiter_bData;
  end
  // x0 writes are accepted upstream but never reach the register file
  always_ff @(posedge i_regfile_wb_arbiter_clk) begin
    if (i_regfile_wb_arbiter_rst) begin
      o_regfile_wb_arbiter_we <= 1'b0;
      o_regfile_wb_arbiter_writeAddr <= '0;
      o_regfile_wb_arbiter_writeData <= '0;
      o_regfile_wb_arbiter_conflicts <= '0;
    end else begin
      o_regfile_wb_arbiter_we <= xfer && (g_addr != '0);
      if (xfer) begin
        o_regfile_wb_arbiter_writeAddr <= g_addr;
        o_regfile_wb_arbiter_writeData <= g_data;
      end
      if (i_regfile_wb_arbiter_aValid && i_regfile_wb_arbiter_bValid && !(&o_regfile_wb_arbiter_conflicts))
        o_regfile_wb_arbiter_conflicts <= o_regfile_wb_arbiter_conflicts + 1'b1;
    end
  end
`ifdef REGFILE_WB_FWD_EN
  assign o_regfile_wb_arbiter_fwd1 = o_regfile_wb_arbiter_we && (o_regfile_wb_arbiter_writeAddr == i_regfile_wb_arbiter_ra1) && (i_regfile_wb_arbiter_ra1 != '0);
  assign o_regfile_wb_arbiter_fwd2 = o_regfile_wb_arbiter_we && (o_regfile_wb_arbiter_writeAddr == i_regfile_wb_arbiter_ra2) && (i_regfile_wb_arbiter_ra2 != '0);
  assign o_regfile_wb_arbiter_fwdData = o_regfile_wb_arbiter_writeData;
`endif
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: directed stimulus with a per-cycle reference model of the writeback arbiter
module tb_regfile_wb_arbiter;
  localparam int MAX_WAIT = 3;
  localparam int CNT_W = 16;
  logic clk = 1'b0;
  logic rst;
  logic av, bv, a_rdy, b_rdy, we;
  logic [4:0] a_addr, b_addr, w_addr;
  logic [31:0] a_data, b_data, w_data;
  logic [CNT_W-1:0] conflicts;
`ifdef REGFILE_WB_FWD_EN
  logic [4:0] ra1, ra2;
  logic fwd1, fwd2;
  logic [31:0] fwd_data;
`endif
  int pass_cnt = 0;
  int total_cnt = 0;
  regfile_wb_arbiter #(.MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)) dut (
    .i_regfile_wb_arbiter_clk       (clk),
    .i_regfile_wb_arbiter_rst       (rst),
    .i_regfile_wb_arbiter_aValid    (av),
    .i_regfile_wb_arbiter_aAddr     (a_addr),
    .i_regfile_wb_arbiter_aData     (a_data),
    .o_regfile_wb_arbiter_aReady    (a_rdy),
    .i_regfile_wb_arbiter_bValid    (bv),
    .i_regfile_wb_arbiter_bAddr     (b_addr),
    .i_regfile_wb_arbiter_bData     (b_data),
    .o_regfile_wb_arbiter_bReady    (b_rdy),
    .o_regfile_wb_arbiter_we        (we),
    .o_regfile_wb_arbiter_writeAddr (w_addr),
    .o_regfile_wb_arbiter_writeData (w_data),
`ifdef REGFILE_WB_FWD_EN
    .i_regfile_wb_arbiter_ra1       (ra1),
    .i_regfile_wb_arbiter_ra2       (ra2),
    .o_regfile_wb_arbiter_fwd1      (fwd1),
    .o_regfile_wb_arbiter_fwd2      (fwd2),
    .o_regfile_wb_arbiter_fwdData   (fwd_data),
`endif
    .o_regfile_wb_arbiter_conflicts (conflicts)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  // Reference model: A waits while B is preferred, and wins once it has been held MAX_WAIT cycles
  int m_wait = 0;
  logic m_we = 1'b0;
  logic [4:0] m_addr = '0;
  logic [31:0] m_data = '0;
  int m_conf = 0;
  logic ga, gb;
  always @(negedge clk) begin
    ga = !rst && av && (!bv || m_wait >= MAX_WAIT);
    gb = !rst && bv && !ga;
    chk("m_aReady", a_rdy, ga);
    chk("m_bReady", b_rdy, gb);
    chk("m_we", we, m_we);
    chk("m_writeAddr", w_addr, m_addr);
    chk("m_writeData", w_data, m_data);
    chk("m_conflicts", conflicts, m_conf);
`ifdef REGFILE_WB_FWD_EN
    chk("m_fwd1", fwd1, m_we && m_addr == ra1 && ra1 != 0);
    chk("m_fwd2", fwd2, m_we && m_addr == ra2 && ra2 != 0);
    chk("m_fwdData", fwd_data, m_data);
`endif
    if (rst) begin
      m_we = 1'b0; m_addr = '0; m_data = '0; m_conf = 0; m_wait = 0;
    end else begin
      m_we = (ga || gb) && ((ga ? a_addr : b_addr) != 0);
      if (ga || gb) begin
        m_addr = ga ? a_addr : b_addr;
        m_data = ga ? a_data : b_data;
      end
      if (av && bv && m_conf < (1 << CNT_W) - 1) m_conf++;
      m_wait = (av && !ga) ? m_wait + 1 : 0;
    end
  end
  logic [7:0] seq;
  logic [3:0] seq2;
  initial begin
    rst = 1'b1; av = 1'b1; bv = 1'b1;
    a_addr = 5'd1; a_data = 32'h1; b_addr = 5'd2; b_data = 32'h2;
`ifdef REGFILE_WB_FWD_EN
    ra1 = '0; ra2 = '0;
`endif
    @(negedge clk);
    chk("rst_aReady", a_rdy, 0);
    chk("rst_bReady", b_rdy, 0);
    chk("rst_we", we, 0);
    chk("rst_conflicts", conflicts, 0);
    step(); rst = 1'b0; av = 1'b0; bv = 1'b0;
    step();
    @(negedge clk);
    chk("idle_we", we, 0);
    step(); av = 1'b1; a_addr = 5'd5; a_data = 32'hDEADBEEF;
    @(negedge clk);
    chk("aonly_aReady", a_rdy, 1);
    step(); av = 1'b0;
    @(negedge clk);
    chk("aonly_we", we, 1);
    chk("aonly_addr", w_addr, 5);
    chk("aonly_data", w_data, 32'hDEADBEEF);
    step(); av = 1'b1; bv = 1'b1; a_addr = 5'd3; a_data = 32'hAAAA; b_addr = 5'd4; b_data = 32'hBBBB;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      seq[i] = a_rdy;
      step();
    end
    av = 1'b0; bv = 1'b0;
    chk("grant_seq", seq, 8'h88);
    @(negedge clk);
    chk("both_conflicts", conflicts, 8);
    step(); bv = 1'b1; b_addr = 5'd0; b_data = 32'h1234;
    @(negedge clk);
    chk("x0_bReady", b_rdy, 1);
    step(); bv = 1'b0;
    @(negedge clk);
    chk("x0_we", we, 0);
    step(); av = 1'b1; bv = 1'b1; a_addr = 5'd9; a_data = 32'h77; b_addr = 5'd10; b_data = 32'h99;
    step();
    step(); bv = 1'b0;
    step(); rst = 1'b1; bv = 1'b1;
    @(negedge clk);
    chk("mid_we_before", we, 1);
    chk("mid_rst_aReady", a_rdy, 0);
    chk("mid_rst_bReady", b_rdy, 0);
    step(); rst = 1'b0;
    @(negedge clk);
    chk("mid_we_after", we, 0);
    chk("mid_conflicts", conflicts, 0);
    for (int i = 0; i < 4; i++) begin
      seq2[i] = a_rdy;
      step();
      @(negedge clk);
    end
    chk("post_rst_seq", seq2, 4'b1000);
    step(); av = 1'b1; bv = 1'b0; a_addr = 5'd7; a_data = 32'h55;
    step(); av = 1'b0;
`ifdef REGFILE_WB_FWD_EN
    ra1 = 5'd7; ra2 = 5'd0;
    @(negedge clk);
    chk("fwd1", fwd1, 1);
    chk("fwd2", fwd2, 0);
    chk("fwdData", fwd_data, 32'h55);
`else
    @(negedge clk);
    chk("x7_data", w_data, 32'h55);
`endif
    step();
    step();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Shares the register file's single write port between two writeback requesters in the multicycle CPU: the execute stage (port A, ALU/immediate results) and the memory stage (port B, load data). It arbitrates with fixed priority to B plus a starvation guard for A, and registers the winning write onto the register file's we/writeAddr/writeData inputs. It optionally exposes a forwarding match on the registered write for the two read addresses.

## Interface
Parameters:
- MAX_WAIT, 3: cycles A may be held while valid before it takes priority; legal range 1..15.
- CNT_W, 16: width of the saturating conflict counter.

Ports:
- i_regfile_wb_arbiter_clk, in, 1: the single clock.
- i_regfile_wb_arbiter_rst, in, 1: synchronous, active-high reset.
- i_regfile_wb_arbiter_aValid, in, 1: A has a write pending.
- i_regfile_wb_arbiter_aAddr, in, 5: A destination register.
- i_regfile_wb_arbiter_aData, in, 32: A write data.
- o_regfile_wb_arbiter_aReady, out, 1: A is granted this cycle.
- i_regfile_wb_arbiter_bValid / bAddr / bData, in, 1/5/32: same fields for B.
- o_regfile_wb_arbiter_bReady, out, 1: B is granted this cycle.
- o_regfile_wb_arbiter_we, out, 1: register file write enable.
- o_regfile_wb_arbiter_writeAddr, out, 5: register file write address.
- o_regfile_wb_arbiter_writeData, out, 32: register file write data.
- o_regfile_wb_arbiter_conflicts, out, CNT_W: count of cycles in which both requesters were valid; saturates.
- i_regfile_wb_arbiter_ra1 / ra2, in, 5: read addresses (present only with REGFILE_WB_FWD_EN).
- o_regfile_wb_arbiter_fwd1 / fwd2, out, 1: forwarding match for ra1 / ra2 (present only with REGFILE_WB_FWD_EN).
- o_regfile_wb_arbiter_fwdData, out, 32: forwarded data (present only with REGFILE_WB_FWD_EN).

## Operation
- A transfer occurs when valid and ready are both high on a port. At most one ready is high per cycle.
- Ready is combinational from the valids and the internal wait counter. Ready never depends on the outputs.
- Grant rules, in order:
  - Only A valid: grant A.
  - Only B valid: grant B.
  - Both valid and waitCnt == MAX_WAIT: grant A.
  - Both valid otherwise: grant B.
- waitCnt is 4 bits:
  - Cleared whenever A is granted or A is not valid.
  - Incremented when A is valid and not granted, saturating at MAX_WAIT.
- The arbiter FSM has two states:
  - PRIO_B: the default.
  - PRIO_A: entered when waitCnt reaches MAX_WAIT; left after the A grant.
- Registered write stage, updated every cycle:
  - we <= transfer && (granted addr != 0).
  - writeAddr/writeData <= granted fields when a transfer occurs, otherwise held.
  - A write to x0 is accepted (ready high) and dropped (we low).
- conflicts increments by 1 in each cycle where aValid && bValid, and saturates at 2^CNT_W−1.
- Requesters hold valid, addr and data stable until their ready is seen. The block does not check this.
- A requester dropping valid without a transfer is legal. Nothing is recorded and waitCnt clears.

## Timing
- Latency: 1 cycle from the transfer edge to we on the register file; the data is visible to reads on the following cycle.
- Throughput: 1 write per cycle. With both ports continuously valid, A wins 1 of every MAX_WAIT+1 cycles.
- Reset values: we=0, writeAddr=0, writeData=0, conflicts=0, waitCnt=0, state=PRIO_B.
- aReady and bReady are 0 while rst is high.
- Reset asserted mid-operation: any write in the registered stage is discarded (we=0 next cycle), and the pending requests are not granted during reset.
- Both ports target the same register in the same cycle: only the winner writes that cycle. The loser writes later, so program order is the requesters' responsibility.

## Configuration
- Macro: REGFILE_WB_FWD_EN.
- Defined:
  - fwdN = we && (writeAddr == raN) && (raN != 0).
  - fwdData = writeData, combinational.
- Undefined: ra1/ra2/fwd1/fwd2/fwdData ports are absent, and no compare logic is built.

## Structure
- The shared package holds:
  - REG_ADDR_W=5 and XLEN=32.
  - The state encoding localparams PRIO_B=1'b0 and PRIO_A=1'b1.
- One sub-module is natural: regfile_wb_prio, which contains the combinational grant logic plus waitCnt/FSM and emits aGrant/bGrant.
- The top level holds the registered write stage, the conflict counter and the forwarding compare.

## Test plan
- Reset then idle: all outputs 0 and both readys 0 while rst is high. With no valids, we stays 0.
- A only (aAddr=5, aData=0xDEADBEEF): aReady=1 the same cycle. Next cycle we=1, writeAddr=5, writeData=0xDEADBEEF.
- Both valid continuously for 8 cycles, MAX_WAIT=3:
  - Grant sequence B,B,B,A,B,B,B,A.
  - conflicts=8.
- B write to x0 (bData=0x1234): bReady=1, and we stays 0 the next cycle.
- Reset mid-stream: raise rst in the cycle after an A transfer. we=0 the next cycle, and conflicts and waitCnt return to 0.
- With REGFILE_WB_FWD_EN, after a write of x7 = 0x55: ra1=7 gives fwd1=1 and fwdData=0x55; ra2=0 gives fwd2=0. Without the macro, the bench compiles with no fwd ports.
